// File: rtl/ksa16_pkg.sv
// Shared definitions for the ksa16 Wishbone front end: register offsets,
// CTRL/STATUS bit positions, FSM state encoding and a byte-lane merge helper.
package ksa16_pkg;

    localparam logic [4:0] OFF_OPA    = 5'h00;
    localparam logic [4:0] OFF_OPB    = 5'h04;
    localparam logic [4:0] OFF_CTRL   = 5'h08;
    localparam logic [4:0] OFF_STATUS = 5'h0C;
    localparam logic [4:0] OFF_RESULT = 5'h10;

    localparam int unsigned CTRL_CIN   = 32'd0;
    localparam int unsigned CTRL_START = 32'd1;
    localparam int unsigned CTRL_ACC   = 32'd2;

    localparam int unsigned STAT_DONE  = 32'd1;
    localparam int unsigned STAT_OVR   = 32'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Replace only the byte lanes selected by sel in a 16-bit register.
    function automatic logic [15:0] merge_lanes(input logic [15:0] cur,
                                                input logic [15:0] wd,
                                                input logic [1:0]  sel);
        merge_lanes = {(sel[1] ? wd[15:8] : cur[15:8]),
                       (sel[0] ? wd[7:0]  : cur[7:0])};
    endfunction

endpackage

// File: rtl/ksa16_wb_regs.sv
// Wishbone slave register block: address decode, single-cycle ack,
// operand/control/status registers and registered readback mux.
module ksa16_wb_regs
    import ksa16_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFE0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        busy,
    input  logic        done_set,
    input  logic        cout,
    input  logic [15:0] sum,
    output logic [15:0] opa,
    output logic [15:0] opb,
    output logic        cin,
    output logic        acc_mode,
    output logic [7:0]  iter,
    output logic        start_pulse
);

    logic        hit_s;
    logic        xfer_s;
    logic        wr_s;
    logic [4:0]  off_s;
    logic        wr_opa_s;
    logic        wr_opb_s;
    logic        wr_ctrl_s;
    logic        wr_status_s;
    logic [31:0] rd_data_s;
    logic        start_req_s;
    logic        start_acc_s;
    logic        ovr_set_s;
    logic        done_clr_s;
    logic        ovr_clr_s;
    logic        done_r;
    logic        ovr_r;
    logic        unused_s;

    assign hit_s  = ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
    // The ack toggles off after each transfer so a held strobe gets one ack per two cycles.
    assign xfer_s = wbs_cyc_i & wbs_stb_i & hit_s & ~wbs_ack_o;
    assign wr_s   = xfer_s & wbs_we_i;
    assign off_s  = {wbs_adr_i[4:2], 2'b00};

    assign start_req_s = wr_ctrl_s & wbs_sel_i[0] & wbs_dat_i[CTRL_START];
    assign start_acc_s = start_req_s & ~busy;
    assign ovr_set_s   = start_req_s & busy;
    assign done_clr_s  = wr_status_s & wbs_sel_i[0] & wbs_dat_i[STAT_DONE];
    assign ovr_clr_s   = wr_status_s & wbs_sel_i[0] & wbs_dat_i[STAT_OVR];

    assign unused_s = ^{wbs_dat_i[31:16], wbs_sel_i[3:2]};

    // Offset decode into per-register write enables and the readback value.
    always_comb begin
        wr_opa_s    = 1'b0;
        wr_opb_s    = 1'b0;
        wr_ctrl_s   = 1'b0;
        wr_status_s = 1'b0;
        rd_data_s   = 32'h0000_0000;
        case (off_s)
            OFF_OPA: begin
                wr_opa_s  = wr_s;
                rd_data_s = {16'h0000, opa};
            end
            OFF_OPB: begin
                wr_opb_s  = wr_s;
                rd_data_s = {16'h0000, opb};
            end
            OFF_CTRL: begin
                wr_ctrl_s = wr_s;
                rd_data_s = {16'h0000, iter, 5'b00000, acc_mode, 1'b0, cin};
            end
            OFF_STATUS: begin
                wr_status_s = wr_s;
                rd_data_s   = {28'h000_0000, ovr_r, cout, done_r, busy};
            end
            OFF_RESULT: begin
                rd_data_s = {15'h0000, cout, sum};
            end
            default: begin
                rd_data_s = 32'h0000_0000;
            end
        endcase
    end

    // Bus handshake, register writes and status bit bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= 32'h0000_0000;
            opa         <= 16'h0000;
            opb         <= 16'h0000;
            cin         <= 1'b0;
            acc_mode    <= 1'b0;
            iter        <= 8'h00;
            start_pulse <= 1'b0;
            done_r      <= 1'b0;
            ovr_r       <= 1'b0;
        end else begin
            wbs_ack_o   <= xfer_s;
            wbs_dat_o   <= (xfer_s & ~wbs_we_i) ? rd_data_s : 32'h0000_0000;
            start_pulse <= start_acc_s;
            if (wr_opa_s) begin
                opa <= merge_lanes(opa, wbs_dat_i[15:0], wbs_sel_i[1:0]);
            end
            if (wr_opb_s) begin
                opb <= merge_lanes(opb, wbs_dat_i[15:0], wbs_sel_i[1:0]);
            end
            if (wr_ctrl_s & wbs_sel_i[0]) begin
                cin      <= wbs_dat_i[CTRL_CIN];
                acc_mode <= wbs_dat_i[CTRL_ACC];
            end
            if (wr_ctrl_s & wbs_sel_i[1]) begin
                iter <= wbs_dat_i[15:8];
            end
            // Completion wins over a simultaneous write-1-to-clear.
            if (done_set) begin
                done_r <= 1'b1;
            end else if (start_acc_s | done_clr_s) begin
                done_r <= 1'b0;
            end
            if (ovr_set_s) begin
                ovr_r <= 1'b1;
            end else if (ovr_clr_s) begin
                ovr_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ksa16_wb_ctrl.sv
// Wishbone front end for the 16-bit Kogge-Stone adder: register block plus
// the FSM that loads operands, iterates accumulation and reports completion.
module ksa16_wb_ctrl
    import ksa16_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFE0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] add_a_o,
    output logic [15:0] add_b_o,
    output logic        add_cin_o,
    input  logic [15:0] add_sum_i,
    input  logic        add_cout_i,
    output logic        irq_o
);

    state_t      state_r;
    logic [7:0]  remaining_r;
    logic [15:0] sum_r;
    logic        cout_r;
    logic        busy_s;
    logic        done_set_s;
    logic [15:0] opa_s;
    logic [15:0] opb_s;
    logic        cin_s;
    logic        acc_mode_s;
    logic [7:0]  iter_s;
    logic        start_pulse_s;

    assign busy_s     = (state_r != IDLE);
    // Covers the edge into DONE and the DONE cycle itself so a racing W1C cannot drop it.
    assign done_set_s = ((state_r == ADD) && (remaining_r == 8'd1)) || (state_r == DONE);

    ksa16_wb_regs #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_MASK (ADDR_MASK)
    ) u_regs (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .busy        (busy_s),
        .done_set    (done_set_s),
        .cout        (cout_r),
        .sum         (sum_r),
        .opa         (opa_s),
        .opb         (opb_s),
        .cin         (cin_s),
        .acc_mode    (acc_mode_s),
        .iter        (iter_s),
        .start_pulse (start_pulse_s)
    );

    // Operation sequencer: latch operands, run N adder passes, pulse irq.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= IDLE;
            remaining_r <= 8'h00;
            sum_r       <= 16'h0000;
            cout_r      <= 1'b0;
            add_a_o     <= 16'h0000;
            add_b_o     <= 16'h0000;
            add_cin_o   <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            irq_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_pulse_s) begin
                        if (acc_mode_s && (iter_s != 8'd0)) begin
                            remaining_r <= iter_s;
                        end else begin
                            remaining_r <= 8'd1;
                        end
                        cout_r  <= 1'b0;
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    add_a_o   <= opa_s;
                    add_b_o   <= opb_s;
                    add_cin_o <= cin_s;
                    state_r   <= ADD;
                end
                ADD: begin
                    sum_r       <= add_sum_i;
                    cout_r      <= cout_r | add_cout_i;
                    // Feed the sum back; carry-in only applies to the first pass.
                    add_a_o     <= add_sum_i;
                    add_cin_o   <= 1'b0;
                    remaining_r <= remaining_r - 8'd1;
                    if (remaining_r == 8'd1) begin
                        state_r <= DONE;
                        irq_o   <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ksa16_wb_ctrl.sv
// Directed bench for ksa16_wb_ctrl with a behavioural 16-bit adder in the
// loop; expected values are hand-computed constants.
module tb_ksa16_wb_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic [15:0] a, b, sum;
    logic        cin, cout, irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] rdv;
    int          lat, first, cnt;
    logic [3:0]  pat;
    logic        any_ack;

    always #5 clk = ~clk;

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'h0000, cin};

    ksa16_wb_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_w),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_r),
        .add_a_o    (a),
        .add_b_o    (b),
        .add_cin_o  (cin),
        .add_sum_i  (sum),
        .add_cout_i (cout),
        .irq_o      (irq)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One Wishbone transfer, called at a falling edge; returns at the falling edge of the ack cycle.
    task automatic wb_xfer(input logic w, input logic [4:0] off, input logic [31:0] wd,
                           input logic [3:0] s, output logic [31:0] rd, output int l);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s;
        adr = BASE | {27'd0, off}; dat_w = wd;
        l = 0; rd = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (ack) begin
                l  = k;
                rd = dat_r;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (l == 0) check_val("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] wd);
        logic [31:0] d;
        int l;
        wb_xfer(1'b1, off, wd, 4'hF, d, l);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] d;
        int l;
        wb_xfer(1'b0, off, 32'h0, 4'hF, d, l);
        check_val(tag, d, exp);
    endtask

    task automatic wait_irq(output int f, output int c);
        f = 0; c = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (irq) begin
                c++;
                if (f == 0) f = k;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; dat_w = 32'h0;
        repeat (3) @(negedge clk);
        check_val("rst_ack",   {31'd0, ack}, 32'd0);
        check_val("rst_dat",   dat_r, 32'd0);
        check_val("rst_ab",    {a, b}, 32'd0);
        check_val("rst_cinirq", {30'd0, cin, irq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rd_chk("rst_status", 5'h0C, 32'h0);
        rd_chk("rst_result", 5'h10, 32'h0);

        // Single add, irq expected three cycles after the start ack.
        wr(5'h00, 32'h1234);
        wr(5'h04, 32'h4321);
        wr(5'h08, 32'h002);
        wait_irq(first, cnt);
        check_val("single_irq_cycle", first, 32'd3);
        check_val("single_irq_count", cnt, 32'd1);
        rd_chk("single_result", 5'h10, 32'h0000_5555);
        rd_chk("single_status", 5'h0C, 32'h2);
        rd_chk("single_ctrl",   5'h08, 32'h0);

        // Carry-in and carry-out.
        wr(5'h00, 32'hFFFF);
        wr(5'h04, 32'h0001);
        wr(5'h08, 32'h003);
        wait_irq(first, cnt);
        check_val("carry_irq_cycle", first, 32'd3);
        rd_chk("carry_result", 5'h10, 32'h0001_0001);
        rd_chk("carry_status", 5'h0C, 32'h6);

        // Accumulate 4 times: 0x10 + 4*3 = 0x1C; status read lands in LOAD.
        wr(5'h00, 32'h0010);
        wr(5'h04, 32'h0003);
        wr(5'h08, 32'h0406);
        rd_chk("acc_status_busy", 5'h0C, 32'h1);
        wait_irq(first, cnt);
        check_val("acc_irq_cycle", first, 32'd4);
        check_val("acc_irq_count", cnt, 32'd1);
        rd_chk("acc_result", 5'h10, 32'h0000_001C);
        rd_chk("acc_status", 5'h0C, 32'h2);

        // Overrun: OPA rewrite and a second start while running.
        wr(5'h08, 32'h0406);
        wr(5'h00, 32'hFFFF);
        wr(5'h08, 32'h0406);
        wait_irq(first, cnt);
        check_val("ovr_irq_count", cnt, 32'd1);
        rd_chk("ovr_result", 5'h10, 32'h0000_001C);
        rd_chk("ovr_status", 5'h0C, 32'hA);
        rd_chk("ovr_opa",    5'h00, 32'h0000_FFFF);
        rd_chk("ovr_ctrl",   5'h08, 32'h0000_0404);
        wr(5'h0C, 32'hA);
        rd_chk("w1c_status", 5'h0C, 32'h0);

        // Byte-lane writes.
        wr(5'h04, 32'h1234);
        wb_xfer(1'b1, 5'h04, 32'h0000_ABCD, 4'b0001, rdv, lat);
        rd_chk("lane0_opb", 5'h04, 32'h0000_12CD);
        wb_xfer(1'b1, 5'h04, 32'h0000_5600, 4'b0010, rdv, lat);
        rd_chk("lane1_opb", 5'h04, 32'h0000_56CD);

        // Reset in the middle of a 4-iteration run.
        wr(5'h00, 32'h0010);
        wr(5'h04, 32'h0003);
        wr(5'h08, 32'h0406);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_ab",     {a, b}, 32'd0);
        check_val("midrst_cinirq", {30'd0, cin, irq}, 32'd0);
        check_val("midrst_ack",    {31'd0, ack}, 32'd0);
        rd_chk("midrst_status", 5'h0C, 32'h0);
        rd_chk("midrst_result", 5'h10, 32'h0);
        rd_chk("midrst_opa",    5'h00, 32'h0);
        rd_chk("midrst_ctrl",   5'h08, 32'h0);
        wr(5'h00, 32'h0002);
        wr(5'h04, 32'h0005);
        wr(5'h08, 32'h002);
        wait_irq(first, cnt);
        check_val("fresh_irq_cycle", first, 32'd3);
        rd_chk("fresh_result", 5'h10, 32'h0000_0007);

        // Unmapped offset: one-cycle ack, reads 0, writes ignored.
        @(negedge clk);
        wb_xfer(1'b0, 5'h14, 32'h0, 4'hF, rdv, lat);
        check_val("unmapped_latency", lat, 32'd1);
        check_val("unmapped_data", rdv, 32'h0);
        wr(5'h14, 32'hFFFF_FFFF);
        rd_chk("unmapped_after_wr", 5'h14, 32'h0);

        // Held strobe: ack alternates.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[3 - i] = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        check_val("b2b_ack_pattern", {28'd0, pat}, 32'hA);

        // Address outside the window gets no ack.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h20;
        any_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            any_ack = any_ack | ack;
        end
        cyc = 1'b0; stb = 1'b0;
        check_val("miss_no_ack", {31'd0, any_ack}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
